// File: rtl/fp32_mul_seq.sv
// -----------------------------------------------------------------------------
// fp32_mul_seq
//   Sequential IEEE-754 single-precision multiplier. Operands are unpacked on
//   acceptance. The 48-bit mantissa product is then built by radix-2
//   shift-and-add, one partial product per cycle over 24 cycles. The result is
//   normalised, rounded to nearest-even, packed, and held on the output port
//   until it is taken. Denormal inputs are treated as zero, and underflowing
//   results are flushed to zero.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
//   ready are both high. o_valid/o_data/flags are held stable until i_ready is
//   sampled high. i_valid is ignored whenever o_ready is low. A result transfer
//   and a new acceptance never happen on the same edge.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_valid      operand pair valid
//   o_ready      core idle, can accept operands
//   i_data_one   operand A, packed fp32
//   i_data_two   operand B, packed fp32
//   o_valid      result valid, held until taken
//   i_ready      downstream accepts result
//   o_data       packed fp32 product
//   o_overflow   result overflowed to +/-inf
//   o_underflow  result flushed to +/-0 from nonzero operands
//   o_invalid    inf*0 or NaN operand
//   o_inexact    guard/sticky nonzero, or overflow/underflow occurred
//   o_dbg_state  current FSM state (IDLE=0 MUL=1 NORM=2 RND=3 OUT=4)
// -----------------------------------------------------------------------------
module fp32_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data_one,
  input  logic [31:0] i_data_two,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_invalid,
  output logic        o_inexact,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_NORM = 3'd2,
    S_RND  = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] data_q;
  logic        ovf_q, unf_q, inv_q, inx_q;

  logic        sign_q;
  logic        special_q;
  logic [31:0] spec_data_q;
  logic        spec_inv_q;
  logic [23:0] mcand_q;
  logic [23:0] mplier_q;
  logic [47:0] p_q;
  logic [4:0]  cnt_q;
  logic [9:0]  exp_q;      // two's complement, biased exponent of the product
  logic [22:0] mant_q;
  logic        guard_q;
  logic        sticky_q;

  // ---------------------------------------------------------------------------
  // Operand decode (used only on the acceptance edge)
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic        sign_d;
  logic        special_d;
  logic [31:0] spec_data_d;
  logic        spec_inv_d;
  logic [9:0]  exp_sum_d;

  always_comb begin
    exp_a  = i_data_one[30:23];
    exp_b  = i_data_two[30:23];
    frac_a = i_data_one[22:0];
    frac_b = i_data_two[22:0];
    // Denormals (exp=0, frac!=0) fold into zero.
    zero_a = (exp_a == 8'h00);
    zero_b = (exp_b == 8'h00);
    inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    sign_d = i_data_one[31] ^ i_data_two[31];

    special_d   = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;
    spec_inv_d  = 1'b0;
    spec_data_d = {sign_d, 31'd0};
    if (nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b)) begin
      spec_inv_d  = 1'b1;
      spec_data_d = 32'h7FC0_0000;
    end else if (inf_a | inf_b) begin
      spec_data_d = {sign_d, 8'hFF, 23'd0};
    end

    exp_sum_d = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
  end

  // ---------------------------------------------------------------------------
  // Shift-and-add step. The 25-bit sum keeps the carry out of P[47] so that
  // it shifts back into P[47] instead of being lost.
  // ---------------------------------------------------------------------------
  logic [24:0] add_d;
  logic [47:0] p_shift_d;

  always_comb begin
    add_d     = {1'b0, p_q[47:24]} + (mplier_q[0] ? {1'b0, mcand_q} : 25'd0);
    p_shift_d = {add_d, p_q[23:1]};
  end

  // ---------------------------------------------------------------------------
  // Normalisation: the product of two [1,2) mantissas lies in [1,4).
  // ---------------------------------------------------------------------------
  logic [22:0] mant_n;
  logic        guard_n, sticky_n;
  logic [9:0]  exp_n;

  always_comb begin
    if (p_q[47]) begin
      mant_n   = p_q[46:24];
      guard_n  = p_q[23];
      sticky_n = |p_q[22:0];
      exp_n    = exp_q + 10'd1;
    end else begin
      mant_n   = p_q[45:23];
      guard_n  = p_q[22];
      sticky_n = |p_q[21:0];
      exp_n    = exp_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Round to nearest-even, then classify the final exponent.
  // ---------------------------------------------------------------------------
  logic        round_up;
  logic [23:0] mant_inc;
  logic [9:0]  exp_r;
  logic        ovf_r, unf_r;

  always_comb begin
    round_up = guard_q & (sticky_q | mant_q[0]);
    mant_inc = {1'b0, mant_q} + {23'd0, round_up};
    // On carry-out the low 23 bits are already zero; only the exponent moves.
    exp_r    = exp_q + {9'd0, mant_inc[23]};
    ovf_r    = ($signed(exp_r) >= $signed(10'sd255));
    unf_r    = ($signed(exp_r) <= $signed(10'sd0));
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      data_q      <= 32'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      inx_q       <= 1'b0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      spec_data_q <= 32'd0;
      spec_inv_q  <= 1'b0;
      mcand_q     <= 24'd0;
      mplier_q    <= 24'd0;
      p_q         <= 48'd0;
      cnt_q       <= 5'd0;
      exp_q       <= 10'd0;
      mant_q      <= 23'd0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid && ready_q) begin
            ready_q     <= 1'b0;
            sign_q      <= sign_d;
            special_q   <= special_d;
            spec_data_q <= spec_data_d;
            spec_inv_q  <= spec_inv_d;
            mcand_q     <= {1'b1, frac_a};
            mplier_q    <= {1'b1, frac_b};
            p_q         <= 48'd0;
            cnt_q       <= 5'd0;
            exp_q       <= exp_sum_d;
            state_q     <= S_MUL;
          end
        end

        S_MUL: begin
          if (special_q) begin
            // Fixed result, presented one edge after acceptance.
            data_q  <= spec_data_q;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= spec_inv_q;
            inx_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_OUT;
          end else begin
            p_q      <= p_shift_d;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == 5'd23) begin
              cnt_q   <= 5'd0;
              state_q <= S_NORM;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        S_NORM: begin
          mant_q   <= mant_n;
          guard_q  <= guard_n;
          sticky_q <= sticky_n;
          exp_q    <= exp_n;
          state_q  <= S_RND;
        end

        S_RND: begin
          inv_q <= 1'b0;
          if (ovf_r) begin
            data_q <= {sign_q, 8'hFF, 23'd0};
            ovf_q  <= 1'b1;
            unf_q  <= 1'b0;
            inx_q  <= 1'b1;
          end else if (unf_r) begin
            data_q <= {sign_q, 31'd0};
            ovf_q  <= 1'b0;
            unf_q  <= 1'b1;
            inx_q  <= 1'b1;
          end else begin
            data_q <= {sign_q, exp_r[7:0], mant_inc[22:0]};
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inx_q  <= guard_q | sticky_q;
          end
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end

        S_OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
  assign o_invalid   = inv_q;
  assign o_inexact   = inx_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_fp32_mul_seq
//   Bench for fp32_mul_seq. A behavioural fp32 multiply model, written with
//   plain integer multiplication, fills an expected queue of
//   {data, ovf, unf, inv, inx} words. One monitor compares the DUT output
//   against the head of the queue on every cycle that o_valid is high. The
//   driver checks acceptance-to-valid latency and that o_ready stays low.
// -----------------------------------------------------------------------------
module tb_fp32_mul_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_one;
  logic [31:0] i_data_two;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_overflow, o_underflow, o_invalid, o_inexact;
  logic [2:0]  o_dbg_state;

  always #5 clk = ~clk;

  fp32_mul_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_one  (i_data_one),
    .i_data_two  (i_data_two),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_invalid   (o_invalid),
    .o_inexact   (o_inexact),
    .o_dbg_state (o_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: returns {data[31:0], ovf, unf, inv, inx}
  // ---------------------------------------------------------------------------
  function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int              ex, ey, e;
    longint unsigned mx, my, p, mant, rem, half;
    logic            zx, zy, ix, iy, nx, ny, s, inx;
    logic [7:0]      e8;
    logic [22:0]     m23;
    ex = x[30:23];
    ey = y[30:23];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    s  = x[31] ^ y[31];
    if (nx || ny || (ix && zy) || (zx && iy)) return {32'h7FC0_0000, 4'b0010};
    if (ix || iy) return {s, 8'hFF, 23'd0, 4'b0000};
    if (zx || zy) return {s, 31'd0, 4'b0000};
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      mant = (p >> 24) & 64'h7F_FFFF;
      rem  = p & 64'hFF_FFFF;
      half = 64'd1 << 23;
      e    = e + 1;
    end else begin
      mant = (p >> 23) & 64'h7F_FFFF;
      rem  = p & 64'h7F_FFFF;
      half = 64'd1 << 22;
    end
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant == (64'd1 << 23)) begin
      mant = 0;
      e    = e + 1;
    end
    inx = (rem != 0);
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b1001};
    if (e <= 0)   return {s, 31'd0, 4'b0101};
    e8  = e[7:0];
    m23 = mant[22:0];
    return {s, e8, m23, 3'b000, inx};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: every cycle with a valid result is compared to the queue head
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {28'd0, o_data, o_overflow, o_underflow, o_invalid, o_inexact}, 64'hDEAD);
      end else begin
        check("result", {28'd0, o_data, o_overflow, o_underflow, o_invalid, o_inexact}, {28'd0, exp_q[0]});
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge+#1)
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1);
  endtask

  // hold: number of cycles i_ready is held low once o_valid is up; i_valid is
  // pulsed with junk operands during that window and must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int   lat;
    logic rdy_low;
    wait_ready();
    i_ready    = (hold == 0);
    i_data_one = a;
    i_data_two = b;
    i_valid    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    i_valid    = 1'b0;
    i_data_one = $urandom;
    i_data_two = $urandom;
    lat = 0;
    rdy_low = 1'b1;
    while (!o_valid && lat < 60) begin
      if (o_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), is_special(a, b) ? 64'd1 : 64'd26);
    check("ready_low_busy", 64'(rdy_low), 64'd1);
    for (int k = 0; k < hold; k++) begin
      i_valid    = k[0];
      i_data_one = $urandom;
      i_data_two = $urandom;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("handback", {62'd0, o_valid, o_ready}, 64'd1);
  endtask

  task automatic check_reset_values(input string name);
    check(name, {28'd0, o_ready, o_valid, o_data, o_overflow, o_underflow, o_invalid, o_inexact},
          {28'd0, 1'b1, 1'b0, 32'd0, 4'b0000});
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors with hand-computed results
  // ---------------------------------------------------------------------------
  localparam int N_DIR = 11;
  logic [31:0] dir_a   [N_DIR] = '{32'h3F800000, 32'h3FC00000, 32'hC0000000, 32'h3F800001,
                                   32'h3FFFFFFF, 32'h7F000000, 32'h00800000, 32'h7F800000,
                                   32'hFF800000, 32'h00000001, 32'h3FFFFFFF};
  logic [31:0] dir_b   [N_DIR] = '{32'h3F800000, 32'h40200000, 32'h40400000, 32'h3F800001,
                                   32'h3FFFFFFF, 32'h7F000000, 32'h00800000, 32'h00000000,
                                   32'h40000000, 32'h40000000, 32'h3F800001};
  logic [35:0] dir_exp [N_DIR] = '{{32'h3F800000, 4'b0000}, {32'h40700000, 4'b0000},
                                   {32'hC0C00000, 4'b0000}, {32'h3F800002, 4'b0001},
                                   {32'h407FFFFE, 4'b0001}, {32'h7F800000, 4'b1001},
                                   {32'h00000000, 4'b0101}, {32'h7FC00000, 4'b0010},
                                   {32'hFF800000, 4'b0000}, {32'h00000000, 4'b0000},
                                   {32'h40000000, 4'b0001}};

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 11))
      0:       v = 32'h0000_0000;
      1:       v = 32'h7F80_0000;
      2:       v = 32'h7FC0_0001;
      3:       v = {9'd0, 23'($urandom_range(1, 8388607))};
      default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    if ($urandom_range(0, 1) == 1) v[31] = ~v[31];
    return v;
  endfunction

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_data_one = 32'd0;
    i_data_two = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    rst_n = 1'b1;

    // Pin the model to hand-computed results, then run them through the DUT.
    for (int i = 0; i < N_DIR; i++) begin
      check($sformatf("model_pin_%0d", i), {28'd0, model(dir_a[i], dir_b[i])}, {28'd0, dir_exp[i]});
    end
    for (int i = 0; i < N_DIR; i++) run_op(dir_a[i], dir_b[i], 0);

    // Result held for 10 cycles with i_valid pulses that must be ignored.
    run_op(32'h3FC00000, 32'h40200000, 10);
    run_op(32'h7F800000, 32'h00000000, 10);

    // Reset one cycle while the multiply is at count 12.
    wait_ready();
    i_data_one = 32'h40490FDB;
    i_data_two = 32'h3F3504F3;
    i_valid    = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_values("reset_mid_mul");
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (o_valid) seen = 1'b1;
      end
      check("no_result_after_reset", 64'(seen), 64'd0);
    end
    run_op(32'h40490FDB, 32'h3F3504F3, 0);

    // Randomized operations with randomized output back-pressure.
    for (int i = 0; i < 150; i++) begin
      run_op(rand_operand(), rand_operand(), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
